fixed_mult_pipe: RTL and testbench
==================================

Name: fixed_mult_pipe

Overview:
- Pipelined, parametrised signed fixed-point multiplier for the fractal iteration datapath (z^2 + c terms).
- Generalises the combinational signed multiplier with:
  - independent input/output Q-formats
  - selectable rounding and saturation
  - an overflow flag
  - a valid/ready handshake with backpressure
  - a sideband tag carried alongside each operand pair.
- Sits between the iteration scheduler and the adder/escape-test stage.

Parameters:
- iD, 16: integer bits of A and B, sign bit included.
- iF, 16: fractional bits of A and B.
- oD, 16: integer bits of O, sign bit included. Legal range 1..2*iD.
- oF, 16: fractional bits of O. Legal range 0..2*iF.
- STAGES, 3: pipeline latency in cycles. Legal range 1..6.
- TW, 8: tag width. Minimum 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  iD+iF  signed operand A, Q(iD).(iF)
- b  in  iD+iF  signed operand B, Q(iD).(iF)
- round_en  in  1  1 = round half toward +inf; 0 = truncate (floor)
- sat_en  in  1  1 = saturate on overflow; 0 = wrap
- tag_in  in  TW  sideband, returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- o  out  oD+oF  signed result, Q(oD).(oF)
- ovf  out  1  result did not fit in Q(oD).(oF) (set regardless of sat_en)
- tag_out  out  TW  tag paired with o

Behaviour:
- Reset (synchronous, active-high):
  - All stage valid bits clear; out_valid=0, o=0, ovf=0, tag_out=0.
  - in_ready=1 in the cycle after reset deasserts.
  - Reset asserted mid-operation discards every in-flight operation; no result from before reset ever appears.
- Handshake:
  - Transfer-in occurs when in_valid && in_ready.
  - Transfer-out occurs when out_valid && out_ready.
  - Global stall: stall = out_valid && !out_ready; in_ready = !stall.
  - During stall, every stage register holds, including o, ovf and tag_out.
  - When not stalled, each stage advances every cycle. Bubbles (valid=0) propagate and do not stall.
  - Results emerge in acceptance order. None are dropped or duplicated.
- Latency: an accepted pair's result is presented on out_valid exactly STAGES cycles later, absent stalls. Each stall cycle adds one.
- Mode sampling: round_en, sat_en and tag_in are captured with the operands and travel with them. Mode changes never affect in-flight operations.
- Arithmetic:
  - P = A*B, full precision: 2*(iD+iF) bits, 2*iF fractional bits.
  - Shift s = 2*iF - oF, s >= 0.
  - If round_en and s>0: R = (P + 2^(s-1)) >>> s. Otherwise R = P >>> s (arithmetic shift, i.e. floor).
  - Compute R one bit wider than P so the rounding add cannot wrap.
  - ovf=1 iff R lies outside [-2^(oD+oF-1), 2^(oD+oF-1)-1].
  - If sat_en and ovf: o = max positive (0 then all 1s) or min negative (1 then all 0s), chosen by the sign of R.
  - Otherwise o = the low oD+oF bits of R (two's-complement wrap).
- Register placement is free, provided total latency equals STAGES. For STAGES=1, only output registers are used.
- Edge case: -2^(iD-1) * -2^(iD-1) must produce ovf=1 and saturate correctly when 2*iD-1 >= oD.

Test Plan (defaults unless stated; hex is 32-bit Q16.16):
- Basic latency: a=0x00018000 (1.5), b=0xFFFE0000 (-2.0), round_en=0, sat_en=1, tag_in=0x5A, out_ready=1 held.
  - Expect o=0xFFFD0000, ovf=0, tag_out=0x5A, out_valid high exactly 3 cycles after acceptance.
- Overflow modes: a=b=0x00C80000 (200.0).
  - sat_en=1: expect o=0x7FFFFFFF, ovf=1.
  - sat_en=0: expect o=0x9C400000, ovf=1.
  - Repeat with a=0xFF380000 (-200.0), b=0x00C80000: sat_en=1 gives o=0x80000000, ovf=1.
- Rounding: a=0x00000001, b=0x00008000.
  - round_en=0: expect o=0x00000000.
  - round_en=1: expect o=0x00000001.
  - a=0xFFFFFFFF, b=0x00008000: round_en=0 gives 0xFFFFFFFF; round_en=1 gives 0x00000000.
- Backpressure: stream 8 back-to-back pairs (tags 0..7, distinct products) with out_ready=0 from cycle 0.
  - in_ready falls when the first result reaches the output; no acceptance occurs while in_ready=0.
  - Then toggle out_ready 1/0 each cycle: all 8 results appear once, in tag order, with correct values; o, ovf and tag_out stay stable during every stall cycle.
- Reset mid-flight: accept 3 pairs, assert rst for 1 cycle before any has emerged.
  - Expect out_valid=0, o=0, tag_out=0 the next cycle, and no stale result afterwards.
  - A new pair issued after reset returns after exactly 3 cycles.
- Mode mixing / STAGES=1: rebuild with STAGES=1, iD=4, iF=12, oD=8, oF=8.
  - Alternate round_en/sat_en per cycle on consecutive transfers.
  - Each result matches a reference model using the modes captured with its own operands; latency is 1 cycle.

Source files
------------

// File: rtl/fixed_mult_pipe_if.sv
// fixed_mult_pipe_if
//   Bundles the operand/result handshake of fixed_mult_pipe.
//   master : upstream/downstream side (drives operands, modes, tag, out_ready)
//   slave  : the multiplier (drives in_ready, result, overflow, tag_out)
//   Signals:
//     in_valid / in_ready     operand-pair handshake
//     a, b                    signed operands, Q(iD).(iF)
//     round_en, sat_en        per-operation rounding / saturation modes
//     tag_in / tag_out        sideband returned unchanged with the result
//     out_valid / out_ready   result handshake
//     o, ovf                  signed result Q(oD).(oF) and overflow flag
interface fixed_mult_pipe_if #(
    parameter int iD = 16,
    parameter int iF = 16,
    parameter int oD = 16,
    parameter int oF = 16,
    parameter int TW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [iD+iF-1:0]     a;
    logic [iD+iF-1:0]     b;
    logic                 round_en;
    logic                 sat_en;
    logic [TW-1:0]        tag_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [oD+oF-1:0]     o;
    logic                 ovf;
    logic [TW-1:0]        tag_out;

    modport master (
        output in_valid, a, b, round_en, sat_en, tag_in, out_ready,
        input  in_ready, out_valid, o, ovf, tag_out
    );

    modport slave (
        input  in_valid, a, b, round_en, sat_en, tag_in, out_ready,
        output in_ready, out_valid, o, ovf, tag_out
    );
endinterface

// File: rtl/fixed_mult_pipe.sv
// fixed_mult_pipe
//   Pipelined signed fixed-point multiplier for the fractal iteration datapath.
//   Computes A*B at full precision, rescales from Q(iD).(iF)^2 to Q(oD).(oF)
//   with floor or round-half-up, flags overflow and optionally saturates.
//   Latency is STAGES cycles; a single global stall (result valid but not
//   taken) freezes every stage, so results leave in acceptance order.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   fixed_mult_pipe_if.slave (operands, modes, tag, result handshake)
module fixed_mult_pipe #(
    parameter int iD     = 16,
    parameter int iF     = 16,
    parameter int oD     = 16,
    parameter int oF     = 16,
    parameter int STAGES = 3,
    parameter int TW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    fixed_mult_pipe_if.slave bus
);
    localparam int W_IN = iD + iF;
    localparam int W_P  = 2 * W_IN;     // full-precision product
    localparam int W_R  = W_P + 1;      // one guard bit so the rounding add cannot wrap
    localparam int W_O  = oD + oF;
    localparam int S    = 2 * iF - oF;  // right shift from product to output format

    localparam logic signed [W_R-1:0] O_MAX = (W_R'(1) << (W_O - 1)) - W_R'(1);
    localparam logic signed [W_R-1:0] O_MIN = ~O_MAX;
    // 2^(S-1); collapses to zero when S == 0, so rounding degenerates to floor.
    localparam logic signed [W_R-1:0] HALF  = (W_R'(1) << S) >> 1;

    typedef struct packed {
        logic                  valid;
        logic signed [W_P-1:0] prod;
        logic                  round_en;
        logic                  sat_en;
        logic [TW-1:0]         tag;
    } stage_t;

    logic                  stall;
    logic                  out_valid_q;
    logic [W_O-1:0]        o_q;
    logic                  ovf_q;
    logic [TW-1:0]         tag_q;

    logic signed [W_IN-1:0] a_s;
    logic signed [W_IN-1:0] b_s;
    logic signed [W_P-1:0]  prod;
    stage_t                 head;
    stage_t                 tail;

    // A held result blocks the whole pipe; bubbles never stall.
    assign stall        = out_valid_q && !bus.out_ready;
    assign bus.in_ready = !stall;

    assign a_s  = bus.a;
    assign b_s  = bus.b;
    assign prod = a_s * b_s;

    // Modes and tag are captured together with the operands.
    always_comb begin
        head.valid    = bus.in_valid;
        head.prod     = prod;
        head.round_en = bus.round_en;
        head.sat_en   = bus.sat_en;
        head.tag      = bus.tag_in;
    end

    // STAGES-1 product registers; the final stage is the output register.
    if (STAGES == 1) begin : g_direct
        assign tail = head;
    end else begin : g_pipe
        stage_t pipe [STAGES-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                // NOTE: only the valid bits are reset; the payload is always
                // qualified by valid, so it needs no reset value.
                for (int i = 0; i < STAGES - 1; i++) begin
                    pipe[i].valid <= 1'b0;
                end
            end else if (!stall) begin
                pipe[0] <= head;
                for (int i = 1; i < STAGES - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign tail = pipe[STAGES-2];
    end

    logic signed [W_R-1:0] p_ext;
    logic signed [W_R-1:0] half;
    logic signed [W_R-1:0] r;
    logic                  ovf_next;
    logic [W_O-1:0]        o_next;

    // NOTE: combinational logic uses blocking assignments and assigns every
    // output on every path, which keeps it free of inferred latches.
    always_comb begin
        p_ext    = {tail.prod[W_P-1], tail.prod};
        half     = tail.round_en ? HALF : '0;
        r        = (p_ext + half) >>> S;
        ovf_next = (r > O_MAX) || (r < O_MIN);
        if (tail.sat_en && ovf_next) begin
            o_next = r[W_R-1] ? O_MIN[W_O-1:0] : O_MAX[W_O-1:0];
        end else begin
            o_next = r[W_O-1:0];
        end
    end

    // Result payload only changes when a real result arrives, so o/ovf/tag_out
    // keep their last value across bubbles as well as stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            o_q         <= '0;
            ovf_q       <= 1'b0;
            tag_q       <= '0;
        end else if (!stall) begin
            out_valid_q <= tail.valid;
            if (tail.valid) begin
                o_q   <= o_next;
                ovf_q <= ovf_next;
                tag_q <= tail.tag;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.o         = o_q;
    assign bus.ovf       = ovf_q;
    assign bus.tag_out   = tag_q;
endmodule

// File: tb/tb_fixed_mult_pipe.sv
// tb_fixed_mult_pipe
//   Self-checking bench for fixed_mult_pipe. Two instances: the default
//   Q16.16 / STAGES=3 build and a Q4.12 -> Q8.8 / STAGES=1 build. Expected
//   results come from constants or from ref_mult, an integer-arithmetic model
//   of the fixed-point rules.
module tb_fixed_mult_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] o;
        logic        ovf;
        logic [7:0]  tag;
    } res_t;

    fixed_mult_pipe_if #(.iD(16), .iF(16), .oD(16), .oF(16), .TW(8)) u ();
    fixed_mult_pipe #(.iD(16), .iF(16), .oD(16), .oF(16), .STAGES(3), .TW(8)) dut (
        .clk(clk), .rst(rst), .bus(u)
    );

    fixed_mult_pipe_if #(.iD(4), .iF(12), .oD(8), .oF(8), .TW(8)) v ();
    fixed_mult_pipe #(.iD(4), .iF(12), .oD(8), .oF(8), .STAGES(1), .TW(8)) dut1 (
        .clk(clk), .rst(rst), .bus(v)
    );

    // Exact product, divide by 2^s with floor (optionally after adding half
    // an output LSB), then range-check against the output format.
    function automatic longint ref_mult(input longint a, input longint b, input bit rnd,
                                        input bit sat, input int i_f, input int o_d,
                                        input int o_f, output bit ovf);
        longint p, r, mx, mn;
        int s;
        p = a * b;
        s = 2 * i_f - o_f;
        if (rnd && s > 0) p = p + (64'sd1 <<< (s - 1));
        r  = p >>> s;
        mx = (64'sd1 <<< (o_d + o_f - 1)) - 1;
        mn = -mx - 1;
        ovf = (r > mx) || (r < mn);
        if (sat && ovf) return (r < 0) ? mn : mx;
        return r;
    endfunction

    function automatic res_t ref32(input logic [31:0] a, input logic [31:0] b,
                                   input bit rnd, input bit sat, input logic [7:0] tag);
        res_t   e;
        bit     ov;
        longint r;
        r     = ref_mult(longint'($signed(a)), longint'($signed(b)), rnd, sat, 16, 16, 16, ov);
        e.o   = r[31:0];
        e.ovf = ov;
        e.tag = tag;
        return e;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] x;
        x = $urandom;
        if ($urandom_range(1, 0) == 1) x = {{14{x[17]}}, x[17:0]};
        return x;
    endfunction

    // Offers one pair with out_ready held high and waits for its result.
    // lat counts cycles from acceptance until out_valid is seen.
    task automatic issue_a(input logic [31:0] a, input logic [31:0] b, input bit rnd,
                           input bit sat, input logic [7:0] tag, output res_t got,
                           output int lat);
        @(negedge clk);
        u.a = a; u.b = b; u.round_en = rnd; u.sat_en = sat; u.tag_in = tag;
        u.out_ready = 1'b1;
        u.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u.in_valid = 1'b0;
        lat = 1;
        while (!u.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got.o = u.o; got.ovf = u.ovf; got.tag = u.tag_out;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++; if (u.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", u.out_valid); end
        tests_run++; if (u.o !== 32'h0) begin tests_failed++; $display("FAIL reset_o: got %h want 0", u.o); end
        tests_run++; if (u.ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", u.ovf); end
        tests_run++; if (u.tag_out !== 8'h0) begin tests_failed++; $display("FAIL reset_tag: got %h want 0", u.tag_out); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (u.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", u.in_ready); end
        tests_run++; if (v.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_s1_out_valid: got %b want 0", v.out_valid); end
    endtask

    task automatic test_basic_latency();
        res_t got;
        int   lat;
        issue_a(32'h00018000, 32'hFFFE0000, 1'b0, 1'b1, 8'h5A, got, lat);
        tests_run++; if (lat != 3) begin tests_failed++; $display("FAIL basic_latency: got %0d want 3", lat); end
        tests_run++; if (got.o !== 32'hFFFD0000) begin tests_failed++; $display("FAIL basic_o: got %h want FFFD0000", got.o); end
        tests_run++; if (got.ovf !== 1'b0) begin tests_failed++; $display("FAIL basic_ovf: got %b want 0", got.ovf); end
        tests_run++; if (got.tag !== 8'h5A) begin tests_failed++; $display("FAIL basic_tag: got %h want 5A", got.tag); end
    endtask

    task automatic test_overflow();
        logic [31:0] ta [5] = '{32'h00C80000, 32'h00C80000, 32'hFF380000, 32'h80000000, 32'h80000000};
        logic [31:0] tb [5] = '{32'h00C80000, 32'h00C80000, 32'h00C80000, 32'h80000000, 32'h80000000};
        bit          ts [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] te [5] = '{32'h7FFFFFFF, 32'h9C400000, 32'h80000000, 32'h7FFFFFFF, 32'h00000000};
        res_t got;
        int   lat;
        for (int i = 0; i < 5; i++) begin
            issue_a(ta[i], tb[i], 1'b0, ts[i], 8'(i), got, lat);
            tests_run++; if (got.o !== te[i]) begin tests_failed++; $display("FAIL ovf_o[%0d]: got %h want %h", i, got.o, te[i]); end
            tests_run++; if (got.ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag[%0d]: got %b want 1", i, got.ovf); end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] ta [4] = '{32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        bit          tr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] te [4] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        res_t got;
        int   lat;
        for (int i = 0; i < 4; i++) begin
            issue_a(ta[i], 32'h00008000, tr[i], 1'b1, 8'(8'h10 + i), got, lat);
            tests_run++; if (got.o !== te[i]) begin tests_failed++; $display("FAIL round_o[%0d]: got %h want %h", i, got.o, te[i]); end
            tests_run++; if (got.ovf !== 1'b0) begin tests_failed++; $display("FAIL round_ovf[%0d]: got %b want 0", i, got.ovf); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa [8];
        logic [31:0] pb [8];
        res_t q [$];
        res_t e, held;
        int   idx = 0, got_n = 0, fall_at = -1;
        bit   prev_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pa[i] = 32'h00014000 + 32'(i) * 32'h00010000;
            pb[i] = 32'hFFFF0000 - 32'(i) * 32'h00008000;
        end
        for (int cyc = 0; cyc < 80 && got_n < 8; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                tests_run++;
                if (u.o !== held.o || u.ovf !== held.ovf || u.tag_out !== held.tag) begin
                    tests_failed++;
                    $display("FAIL bp_hold: got %h/%b/%h want %h/%b/%h", u.o, u.ovf, u.tag_out, held.o, held.ovf, held.tag);
                end
            end
            u.out_ready = (cyc < 8) ? 1'b0 : cyc[0];
            u.in_valid  = (idx < 8);
            if (idx < 8) begin
                u.a = pa[idx]; u.b = pb[idx]; u.round_en = 1'b0; u.sat_en = 1'b1; u.tag_in = 8'(idx);
            end
            #1;
            if (cyc < 8) begin
                tests_run++;
                if (u.in_ready !== !u.out_valid) begin tests_failed++; $display("FAIL bp_in_ready c%0d: got %b want %b", cyc, u.in_ready, !u.out_valid); end
                if (!u.in_ready && fall_at < 0) fall_at = idx;
            end
            if (u.out_valid && u.out_ready) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++; $display("FAIL bp_extra: got tag %h want none", u.tag_out);
                end else begin
                    e = q.pop_front();
                    if (u.o !== e.o || u.ovf !== e.ovf || u.tag_out !== e.tag) begin
                        tests_failed++;
                        $display("FAIL bp_result: got %h/%b/%h want %h/%b/%h", u.o, u.ovf, u.tag_out, e.o, e.ovf, e.tag);
                    end
                end
                got_n++;
            end
            prev_stall = u.out_valid && !u.out_ready;
            held.o = u.o; held.ovf = u.ovf; held.tag = u.tag_out;
            if (u.in_valid && u.in_ready) begin
                q.push_back(ref32(pa[idx], pb[idx], 1'b0, 1'b1, 8'(idx)));
                idx++;
            end
        end
        u.in_valid = 1'b0; u.out_ready = 1'b1;
        tests_run++; if (fall_at != 3) begin tests_failed++; $display("FAIL bp_accepted_before_stall: got %0d want 3", fall_at); end
        tests_run++; if (got_n != 8) begin tests_failed++; $display("FAIL bp_count: got %0d want 8", got_n); end
        tests_run++; if (q.size() != 0) begin tests_failed++; $display("FAIL bp_leftover: got %0d want 0", q.size()); end
    endtask

    task automatic test_back_to_back();
        res_t        q [$];
        res_t        e;
        logic [31:0] ca = '0, cb = '0;
        bit          cr = 1'b0, cs = 1'b0, offering = 1'b0;
        int          sent = 0, got_n = 0;
        for (int cyc = 0; cyc < 800 && got_n < 40; cyc++) begin
            @(negedge clk);
            if (!offering && sent < 40 && $urandom_range(3, 0) != 0) begin
                ca = rand_operand(); cb = rand_operand();
                cr = 1'($urandom); cs = 1'($urandom);
                offering = 1'b1;
            end
            u.in_valid = offering;
            u.a = ca; u.b = cb; u.round_en = cr; u.sat_en = cs; u.tag_in = 8'(sent);
            u.out_ready = ($urandom_range(2, 0) != 0);
            #1;
            if (u.out_valid && u.out_ready) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++; $display("FAIL b2b_extra: got tag %h want none", u.tag_out);
                end else begin
                    e = q.pop_front();
                    if (u.o !== e.o || u.ovf !== e.ovf || u.tag_out !== e.tag) begin
                        tests_failed++;
                        $display("FAIL b2b_result: got %h/%b/%h want %h/%b/%h", u.o, u.ovf, u.tag_out, e.o, e.ovf, e.tag);
                    end
                end
                got_n++;
            end
            if (u.in_valid && u.in_ready) begin
                q.push_back(ref32(ca, cb, cr, cs, 8'(sent)));
                sent++;
                offering = 1'b0;
            end
        end
        u.in_valid = 1'b0; u.out_ready = 1'b1;
        tests_run++; if (got_n != 40) begin tests_failed++; $display("FAIL b2b_count: got %0d want 40", got_n); end
    endtask

    task automatic test_reset_midflight();
        res_t got, e;
        int   lat;
        bit   stale = 1'b0;
        u.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            u.a = 32'h00030000 + 32'(i); u.b = 32'h00020000; u.round_en = 1'b0; u.sat_en = 1'b1;
            u.tag_in = 8'hA0 + 8'(i); u.in_valid = 1'b1;
            if (i == 2) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0; u.in_valid = 1'b0;
        tests_run++; if (u.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid: got %b want 0", u.out_valid); end
        tests_run++; if (u.o !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_o: got %h want 0", u.o); end
        tests_run++; if (u.tag_out !== 8'h0) begin tests_failed++; $display("FAIL rst_mid_tag: got %h want 0", u.tag_out); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (u.out_valid) stale = 1'b1;
        end
        tests_run++; if (stale) begin tests_failed++; $display("FAIL rst_mid_stale: got stale result want none"); end
        issue_a(32'h00050000, 32'hFFFF8000, 1'b1, 1'b0, 8'h3C, got, lat);
        e = ref32(32'h00050000, 32'hFFFF8000, 1'b1, 1'b0, 8'h3C);
        tests_run++; if (lat != 3) begin tests_failed++; $display("FAIL rst_mid_latency: got %0d want 3", lat); end
        tests_run++; if (got.o !== e.o || got.tag !== e.tag) begin tests_failed++; $display("FAIL rst_mid_result: got %h/%h want %h/%h", got.o, got.tag, e.o, e.tag); end
    endtask

    task automatic test_mode_mixing();
        logic [15:0] ea [16];
        logic        eo [16];
        logic [15:0] a16, b16;
        bit          ov;
        longint      r;
        v.out_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests_run++;
                if (v.out_valid !== 1'b1 || v.o !== ea[i-1] || v.ovf !== eo[i-1] || v.tag_out !== 8'(i - 1)) begin
                    tests_failed++;
                    $display("FAIL s1_result[%0d]: got %b/%h/%b/%h want 1/%h/%b/%h", i - 1, v.out_valid, v.o, v.ovf, v.tag_out, ea[i-1], eo[i-1], 8'(i - 1));
                end
            end
            if (i < 16) begin
                a16 = (i == 0) ? 16'h8000 : 16'($urandom);
                b16 = (i == 0) ? 16'h8000 : 16'($urandom);
                v.a = a16; v.b = b16; v.round_en = i[0]; v.sat_en = i[1]; v.tag_in = 8'(i);
                v.in_valid = 1'b1;
                r = ref_mult(longint'($signed(a16)), longint'($signed(b16)), i[0], i[1], 12, 8, 8, ov);
                ea[i] = r[15:0];
                eo[i] = ov;
            end else begin
                v.in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        u.in_valid = 1'b0; u.out_ready = 1'b1; u.a = '0; u.b = '0;
        u.round_en = 1'b0; u.sat_en = 1'b0; u.tag_in = '0;
        v.in_valid = 1'b0; v.out_ready = 1'b1; v.a = '0; v.b = '0;
        v.round_en = 1'b0; v.sat_en = 1'b0; v.tag_in = '0;
        test_reset();
        test_basic_latency();
        test_overflow();
        test_rounding();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_mode_mixing();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
